// File: rtl/cmplx_pkg.sv
// Shared types and width helpers for the sequential complex multiplier.
// Widths are derived from the operand width so every file agrees on them.
package cmplx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL0,
        MUL1,
        MUL2,
        MUL3,
        DONE
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 16;

    function automatic int prod_width(input int dw);
        return 2 * dw;
    endfunction

    function automatic int res_width(input int dw);
        return 2 * dw + 1;
    endfunction

    localparam int PROD_W = prod_width(DEFAULT_DATA_WIDTH);
    localparam int RES_W  = res_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/real_mult.sv
// Combinational signed DATA_WIDTH x DATA_WIDTH multiplier shared by all partial products.
// Kept as its own module so a pipelined multiplier can be dropped in later.
module real_mult
    import cmplx_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0]             a_i,
    input  logic signed [DATA_WIDTH-1:0]             b_i,
    output logic signed [prod_width(DATA_WIDTH)-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/complex_mult_seq.sv
// Sequencer for p = a*b over complex operands using a single shared real multiplier.
// Four partial products are formed in four consecutive states, then the result is held until taken.
module complex_mult_seq
    import cmplx_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic signed [DATA_WIDTH-1:0]            a_re,
    input  logic signed [DATA_WIDTH-1:0]            a_im,
    input  logic signed [DATA_WIDTH-1:0]            b_re,
    input  logic signed [DATA_WIDTH-1:0]            b_im,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic signed [res_width(DATA_WIDTH)-1:0] p_re,
    output logic signed [res_width(DATA_WIDTH)-1:0] p_im,
    output logic                                    busy
);

    localparam int PROD_WIDTH = prod_width(DATA_WIDTH);
    localparam int RES_WIDTH  = res_width(DATA_WIDTH);

    state_t state_q;

    logic signed [DATA_WIDTH-1:0] a_re_q;
    logic signed [DATA_WIDTH-1:0] a_im_q;
    logic signed [DATA_WIDTH-1:0] b_re_q;
    logic signed [DATA_WIDTH-1:0] b_im_q;

    logic signed [RES_WIDTH-1:0] acc_re_q;
    logic signed [RES_WIDTH-1:0] acc_im_q;
    logic signed [RES_WIDTH-1:0] p_re_q;
    logic signed [RES_WIDTH-1:0] p_im_q;

    logic in_ready_q;
    logic out_valid_q;
    logic busy_q;

    logic signed [DATA_WIDTH-1:0] mul_a;
    logic signed [DATA_WIDTH-1:0] mul_b;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [RES_WIDTH-1:0]  prod_ext;

    // Operand selection depends on state alone; IDLE and DONE feed zeros.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL0: begin
                mul_a = a_re_q;
                mul_b = b_re_q;
            end
            MUL1: begin
                mul_a = a_im_q;
                mul_b = b_im_q;
            end
            MUL2: begin
                mul_a = a_re_q;
                mul_b = b_im_q;
            end
            MUL3: begin
                mul_a = a_im_q;
                mul_b = b_re_q;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    real_mult #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_real_mult (
        .a_i(mul_a),
        .b_i(mul_b),
        .p_o(prod)
    );

    assign prod_ext = {prod[PROD_WIDTH-1], prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_re_q      <= '0;
            a_im_q      <= '0;
            b_re_q      <= '0;
            b_im_q      <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            p_re_q      <= '0;
            p_im_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_re_q     <= a_re;
                        a_im_q     <= a_im;
                        b_re_q     <= b_re;
                        b_im_q     <= b_im;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= MUL0;
                    end
                end
                MUL0: begin
                    acc_re_q <= prod_ext;
                    state_q  <= MUL1;
                end
                MUL1: begin
                    p_re_q  <= acc_re_q - prod_ext;
                    state_q <= MUL2;
                end
                MUL2: begin
                    acc_im_q <= prod_ext;
                    state_q  <= MUL3;
                end
                MUL3: begin
                    p_im_q      <= acc_im_q + prod_ext;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p_re      = p_re_q;
    assign p_im      = p_im_q;

endmodule

// File: tb/tb_complex_mult_seq.sv
// Directed, table-driven bench for complex_mult_seq with hand-computed products
// plus hand-written backpressure, back-to-back and mid-operation reset sequences.
module tb_complex_mult_seq;

    localparam int DW = 16;
    localparam int RW = 2 * DW + 1;
    localparam int NV = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] a_re;
    logic signed [DW-1:0] a_im;
    logic signed [DW-1:0] b_re;
    logic signed [DW-1:0] b_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [RW-1:0] p_re;
    logic signed [RW-1:0] p_im;
    logic                 busy;

    complex_mult_seq #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_re(a_re),
        .a_im(a_im),
        .b_re(b_re),
        .b_im(b_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p_re(p_re),
        .p_im(p_im),
        .busy(busy)
    );

    typedef struct {
        logic signed [DW-1:0] ar;
        logic signed [DW-1:0] ai;
        logic signed [DW-1:0] br;
        logic signed [DW-1:0] bi;
        logic signed [RW-1:0] er;
        logic signed [RW-1:0] ei;
    } vec_t;

    vec_t vecs[NV];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input int ar, input int ai, input int br, input int bi,
                                input longint er, input longint ei);
        vec_t v;
        v.ar = DW'(ar);
        v.ai = DW'(ai);
        v.br = DW'(br);
        v.bi = DW'(bi);
        v.er = RW'(er);
        v.ei = RW'(ei);
        return v;
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        a_re = DW'($urandom_range(65535));
        a_im = DW'($urandom_range(65535));
        b_re = DW'($urandom_range(65535));
        b_im = DW'($urandom_range(65535));
    endtask

    task automatic drive(input vec_t v);
        a_re = v.ar;
        a_im = v.ai;
        b_re = v.br;
        b_im = v.bi;
    endtask

    // One complete transaction; operands are randomised after the accept edge.
    task automatic run_txn(input vec_t v, input string tag);
        int waited = 0;
        int lat = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, " in_ready before accept"}, in_ready, 1);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            scramble();
            tick();
            lat++;
        end
        scramble();
        check({tag, " latency"}, lat, 4);
        check({tag, " p_re"}, p_re, v.er);
        check({tag, " p_im"}, p_im, v.ei);
        check({tag, " in_ready in DONE"}, in_ready, 0);
        check({tag, " busy in DONE"}, busy, 1);
        $display("txn %s: a=(%0d,%0d) b=(%0d,%0d) -> p=(%0d,%0d) exp=(%0d,%0d)",
                 tag, v.ar, v.ai, v.br, v.bi, p_re, p_im, v.er, v.ei);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, out_valid, 0);
        check({tag, " in_ready after handshake"}, in_ready, 1);
        check({tag, " busy after handshake"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc_edge[2];
        int   hs_edge[2];
        int   n_acc;
        int   n_hs;
        int   edge_no;
        int   lat;
        int   spurious;
        vec_t bp;
        vec_t bb[2];
        vec_t rv;

        vecs[0] = mk(3, 4, 5, 6, -9, 38);
        vecs[1] = mk(-32768, -32768, -32768, -32768, 0, 64'sd2147483648);
        vecs[2] = mk(1, -2, -3, 4, 5, 10);
        vecs[3] = mk(1, 1, 1, 1, 0, 2);
        vecs[4] = mk(2, 0, 0, 3, 0, 6);
        vecs[5] = mk(7, -1, 2, 5, 19, 33);
        vecs[6] = mk(-32768, 32767, 32767, -32768, 0, 64'sd2147418113);
        vecs[7] = mk(0, -1, -1, 0, 0, 1);
        vecs[8] = mk(100, -200, -300, 400, 50000, 100000);
        vecs[9] = mk(32767, 32767, -32768, -32768, 0, -64'sd2147418112);

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_re      = '0;
        a_im      = '0;
        b_re      = '0;
        b_im      = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset p_re", p_re, 0);
        check("reset p_im", p_im, 0);

        // out_ready while idle must be ignored
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle out_ready ignored", out_valid, 0);

        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold the result for 10 cycles
        bp = vecs[2];
        drive(bp);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            scramble();
            tick();
            lat++;
        end
        check("bp latency", lat, 4);
        for (int c = 0; c < 10; c++) begin
            check("bp out_valid", out_valid, 1);
            check("bp p_re", p_re, bp.er);
            check("bp p_im", p_im, bp.ei);
            check("bp in_ready", in_ready, 0);
            check("bp busy", busy, 1);
            scramble();
            tick();
        end
        $display("txn backpressure: p=(%0d,%0d) exp=(%0d,%0d)", p_re, p_im, bp.er, bp.ei);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp out_valid after handshake", out_valid, 0);
        check("bp in_ready after handshake", in_ready, 1);

        // Back-to-back with in_valid held high
        bb[0] = vecs[3];
        bb[1] = vecs[4];
        n_acc = 0;
        n_hs = 0;
        edge_no = 0;
        acc_edge[0] = 0;
        acc_edge[1] = 0;
        hs_edge[0] = 0;
        hs_edge[1] = 0;
        drive(bb[0]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && n_hs < 2; c++) begin
            if (in_valid && in_ready && n_acc < 2) begin
                acc_edge[n_acc] = edge_no + 1;
                n_acc++;
            end
            if (out_valid && out_ready) begin
                check($sformatf("b2b%0d p_re", n_hs), p_re, bb[n_hs].er);
                check($sformatf("b2b%0d p_im", n_hs), p_im, bb[n_hs].ei);
                $display("txn b2b%0d: p=(%0d,%0d) exp=(%0d,%0d)",
                         n_hs, p_re, p_im, bb[n_hs].er, bb[n_hs].ei);
                hs_edge[n_hs] = edge_no + 1;
                n_hs++;
            end
            tick();
            edge_no++;
            if (n_acc == 1) drive(bb[1]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b accepts seen", n_acc, 2);
        check("b2b handshakes seen", n_hs, 2);
        check("b2b accept interval", acc_edge[1] - acc_edge[0], 6);
        check("b2b handshake to accept", acc_edge[1] - hs_edge[0], 1);

        // Reset asserted while in MUL2
        tick();
        drive(vecs[8]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("rst-mid busy before reset", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst-mid out_valid", out_valid, 0);
        check("rst-mid in_ready", in_ready, 1);
        check("rst-mid busy", busy, 0);
        check("rst-mid p_re", p_re, 0);
        check("rst-mid p_im", p_im, 0);
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) spurious++;
            tick();
        end
        check("rst-mid spurious out_valid", spurious, 0);
        rv = vecs[5];
        run_txn(rv, "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
